// File: rtl/clock_phase_tracker.sv
// Consumer-side monitor for a two-phase non-overlapping clock interface.
// Locks to the 4-cycle CLK1/CLK2/O_S sequence, reports phase and flags errors.
module clock_phase_tracker #(
  parameter int LOCK_PERIODS = 2,
  parameter int ERR_W        = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLK1,
  input  logic             CLK2,
  input  logic             O_S,
  output logic [1:0]       PHASE,
  output logic             LOCKED,
  output logic             SYNC,
  output logic             ERR,
  output logic             ERR_OVL,
  output logic [ERR_W-1:0] ERR_CNT
);

  typedef enum logic [1:0] {HUNT, CHECK, LOCK} stateT;

  localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_PERIODS);
  localparam logic [ERR_W-1:0] CNT_MAX     = '1;
  localparam logic [2:0]       PAT_P0      = 3'b100;

  stateT            stateReg, stateNext;
  logic [2:0]       sampleReg;
  logic [1:0]       phaseReg, phaseNext;
  logic [3:0]       gcReg, gcNext;
  logic             lockedReg, lockedNext;
  logic             syncReg, syncNext;
  logic             errReg, errNext;
  logic             ovlReg, ovlNext;
  logic [ERR_W-1:0] cntReg, cntNext;

  logic [1:0] expPhase;
  logic       overlap;
  logic       match;

  // Expected {CLK1,CLK2,O_S} sample for each phase of the period.
  function automatic logic [2:0] phasePattern(input logic [1:0] p);
    case (p)
      2'd0:    return 3'b100;
      2'd1:    return 3'b000;
      2'd2:    return 3'b011;
      default: return 3'b001;
    endcase
  endfunction

  assign expPhase = phaseReg + 2'd1;
  assign overlap  = sampleReg[2] & sampleReg[1];
  // No pattern has CLK1 and CLK2 both high, so an overlap can never match.
  assign match    = (sampleReg == phasePattern(expPhase));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sampleReg <= 3'b000;
      stateReg  <= HUNT;
      phaseReg  <= 2'd0;
      gcReg     <= 4'd0;
      lockedReg <= 1'b0;
      syncReg   <= 1'b0;
      errReg    <= 1'b0;
      ovlReg    <= 1'b0;
      cntReg    <= '0;
    end else begin
      sampleReg <= {CLK1, CLK2, O_S};
      stateReg  <= stateNext;
      phaseReg  <= phaseNext;
      gcReg     <= gcNext;
      lockedReg <= lockedNext;
      syncReg   <= syncNext;
      errReg    <= errNext;
      ovlReg    <= ovlNext;
      cntReg    <= cntNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    phaseNext  = phaseReg;
    gcNext     = gcReg;
    lockedNext = lockedReg;
    syncNext   = 1'b0;
    errNext    = 1'b0;
    ovlNext    = ovlReg | overlap;
    cntNext    = cntReg;

    case (stateReg)
      HUNT: begin
        errNext = overlap;
        if (sampleReg == PAT_P0) begin
          stateNext = CHECK;
          phaseNext = 2'd0;
          gcNext    = 4'd0;
        end
      end
      default: begin
        if (match) begin
          phaseNext = expPhase;
          if (expPhase == 2'd0) begin
            if (stateReg == LOCK) begin
              syncNext = 1'b1;
            end else if (gcReg + 4'd1 == LOCK_TARGET) begin
              stateNext  = LOCK;
              lockedNext = 1'b1;
              syncNext   = 1'b1;
            end else begin
              gcNext = gcReg + 4'd1;
            end
          end
        end else begin
          // A fresh phase-0 sample restarts checking without a pass through HUNT.
          errNext    = 1'b1;
          lockedNext = 1'b0;
          phaseNext  = 2'd0;
          gcNext     = 4'd0;
          stateNext  = (sampleReg == PAT_P0) ? CHECK : HUNT;
        end
      end
    endcase

    if (errNext && (cntReg != CNT_MAX)) begin
      cntNext = cntReg + 1'b1;
    end
  end

  assign PHASE   = phaseReg;
  assign LOCKED  = lockedReg;
  assign SYNC    = syncReg;
  assign ERR     = errReg;
  assign ERR_OVL = ovlReg;
  assign ERR_CNT = cntReg;

endmodule
